// File: rtl/npu_fifo_pkg.sv
// Shared types and constants for the NPU FIFO read-side logic.
package npu_fifo_pkg;

  localparam int SKID_DEPTH = 2;
  localparam int STAT_W     = 32;

  typedef logic [1:0] skid_cnt_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/skid_buffer_2.sv
// Two-entry skid buffer: head register drives the output, tail absorbs one
// extra word while the consumer stalls.
//
// state      | meaning
// SKID_EMPTY | no words held, output invalid
// SKID_ONE   | head holds the output word
// SKID_FULL  | head is the output word, tail holds the next one
module skid_buffer_2
  import npu_fifo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output skid_cnt_t        count
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= SKID_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      // Data registers are left as-is; only occupancy matters after a flush.
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (push) begin
            head_d  = push_data;
            state_d = SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (push && pop) begin
            head_d = push_data;
          end else if (push) begin
            tail_d  = push_data;
            state_d = SKID_FULL;
          end else if (pop) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = SKID_ONE;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

  assign valid = (state_q != SKID_EMPTY);
  assign data  = head_q;
  assign count = skid_cnt_t'(state_q);

endmodule

// File: rtl/bram_fifo_reader.sv
// Read-side master for the show-ahead M20K FIFO, presenting a valid/ready stream.
// Optional BRAM_FIFO_READER_STATS_EN adds beat and stall counters.
module bram_fifo_reader
  import npu_fifo_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SKID_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fifo_empty,
  input  logic [WIDTH-1:0]  i_fifo_data,
  output logic              o_fifo_rdreq,
  input  logic              i_flush,
  output logic              o_valid,
  output logic [WIDTH-1:0]  o_data,
  input  logic              i_ready,
  output logic [1:0]        o_buf_count,
  output logic              o_idle
`ifdef BRAM_FIFO_READER_STATS_EN
  ,
  output logic [STAT_W-1:0] o_beat_count,
  output logic [STAT_W-1:0] o_stall_count
`endif
);

  generate
    if (SKID_DEPTH != npu_fifo_pkg::SKID_DEPTH) begin : g_bad_depth
      $error("bram_fifo_reader: SKID_DEPTH must be 2");
    end
  endgenerate

  logic      pop;
  skid_cnt_t buf_count;

  // The pop request looks only at FIFO state and local occupancy, never i_ready,
  // so the consumer's ready path does not reach the FIFO.
  assign o_fifo_rdreq = !i_fifo_empty && (buf_count < 2'd2) && !i_flush && rst;
  assign pop          = o_valid && i_ready;
  assign o_buf_count  = buf_count;
  assign o_idle       = (buf_count == 2'd0) && i_fifo_empty;

  skid_buffer_2 #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (o_fifo_rdreq),
    .pop       (pop),
    .flush     (i_flush),
    .push_data (i_fifo_data),
    .valid     (o_valid),
    .data      (o_data),
    .count     (buf_count)
  );

`ifdef BRAM_FIFO_READER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_beat_count  <= '0;
      o_stall_count <= '0;
    end else begin
      // A pop coincident with flush was not accepted, so it is not a beat.
      if (pop && !i_flush) o_beat_count <= o_beat_count + STAT_W'(1);
      if (o_valid && !i_ready) o_stall_count <= sat_inc(o_stall_count);
    end
  end
`endif

endmodule
